// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver: synchronizes the RX line, deframes LSB-first bytes and
// presents them on a ready/valid port with framing-error and overrun pulses.
module uart_rx_deframer #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned BIT_CYC  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic             sync1_q;
    logic             rx_s_q;
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             deliver_q, deliver_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             ovr_q,     ovr_d;

    // Next-state: bit timing, deframing and the output handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        deliver_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Consumer accept clears valid; a coinciding delivery re-fills it
        if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || data_out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset; 2-flop line synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            deliver_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = ferr_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at a reduced bit period.
module tb_uart_rx_deframer;

    localparam int unsigned CF   = 3_200_000;
    localparam int unsigned BR   = 100_000;
    localparam int unsigned BIT  = CF / BR;     // 32 cycles per bit
    localparam int unsigned HALF = BIT / 2;
    localparam int          LAT_NOM = 9 * BIT + HALF + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;

    uart_rx_deframer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int stab_err = 0;
    int rise_cyc = -1;
    int fall_cyc = 0;
    logic [7:0] got_q[$];
    bit rand_rdy = 1'b0;
    logic pv = 1'b0;
    logic pacc = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: accepted bytes, pulse counts, hold-stability of the output
    always @(negedge clk) begin
        if (rst) begin
            pv   = 1'b0;
            pacc = 1'b0;
        end else begin
            if (pv && !pacc && (!data_out_valid || data_out !== pd)) stab_err++;
            if (!pv && data_out_valid) rise_cyc = cyc;
            if (data_out_valid && data_out_ready) got_q.push_back(data_out);
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            pv   = data_out_valid;
            pacc = data_out_valid && data_out_ready;
            pd   = data_out;
        end
    end

    // Random consumer, only while enabled
    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) data_out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_bit(input logic v);
        serial_in = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        fall_cyc = cyc;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        serial_in = 1'b1;
        if (gap > 0) idle(gap);
    endtask

    task automatic accept_one();
        data_out_ready = 1'b1;
        idle(1);
        data_out_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int fe0, ov0, n0, efe, lat;
        logic [7:0] exp_q[$];

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1};
        tbl[2] = '{8'h41, 1'b1, 1'b1, 8'h41, 0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        tbl[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};

        // Reset and quiet line
        idle(5);
        rst = 1'b0;
        idle(300);
        @(negedge clk);
        chk("reset_valid", 32'(data_out_valid), 0);
        chk("reset_data", 32'(data_out), 32'h00);
        chk("reset_fe", fe_cnt, 0);
        chk("reset_ov", ov_cnt, 0);
        idle(1);

        // Table of single frames with consumer stalled
        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            n0  = got_q.size();
            send_frame(tbl[i].b, tbl[i].stop, BIT);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(data_out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].exp_fe);
            chk($sformatf("tbl%0d_ov", i), ov_cnt - ov0, 0);
            if (i == 0) begin
                lat = rise_cyc - fall_cyc;
                chk("latency_in_range", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
            end
            if (tbl[i].exp_valid) begin
                idle(50);
                @(negedge clk);
                chk($sformatf("tbl%0d_hold_valid", i), 32'(data_out_valid), 1);
                chk($sformatf("tbl%0d_hold_data", i), 32'(data_out), 32'(tbl[i].exp_data));
                idle(1);
                accept_one();
                chk($sformatf("tbl%0d_drop_valid", i), 32'(data_out_valid), 0);
                chk($sformatf("tbl%0d_accepted", i), got_q.size(), n0 + 1);
                if (got_q.size() == n0 + 1)
                    chk($sformatf("tbl%0d_acc_byte", i), 32'(got_q[n0]), 32'(tbl[i].exp_data));
            end
            idle(1);
        end

        // Short low glitch must not start a frame
        fe0 = fe_cnt;
        n0  = got_q.size();
        serial_in = 1'b0;
        idle(HALF / 2);
        serial_in = 1'b1;
        idle(3 * BIT);
        @(negedge clk);
        chk("glitch_valid", 32'(data_out_valid), 0);
        chk("glitch_fe", fe_cnt - fe0, 0);
        idle(1);

        // Back-to-back frames, consumer stalled: second one overruns
        ov0 = ov_cnt;
        n0  = got_q.size();
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, BIT);
        @(negedge clk);
        chk("b2b_stall_valid", 32'(data_out_valid), 1);
        chk("b2b_stall_data", 32'(data_out), 32'h11);
        chk("b2b_stall_ov", ov_cnt - ov0, 1);
        idle(1);
        accept_one();
        chk("b2b_stall_acc_cnt", got_q.size(), n0 + 1);
        idle(1);

        // Back-to-back with consumer always ready: both delivered, no overrun
        ov0 = ov_cnt;
        n0  = got_q.size();
        data_out_ready = 1'b1;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, BIT);
        data_out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_ready_cnt", got_q.size(), n0 + 2);
        if (got_q.size() == n0 + 2) begin
            chk("b2b_ready_first", 32'(got_q[n0]), 32'h11);
            chk("b2b_ready_second", 32'(got_q[n0 + 1]), 32'h22);
        end
        chk("b2b_ready_ov", ov_cnt - ov0, 0);
        idle(1);

        // Reset in the middle of a frame abandons it
        n0 = got_q.size();
        data_out_ready = 1'b1;
        fall_cyc = cyc;
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b1);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(data_out_valid), 0);
        chk("midrst_data", 32'(data_out), 32'h00);
        idle(1);
        idle(8 * BIT);
        send_frame(8'h5A, 1'b1, BIT);
        data_out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_cnt", got_q.size(), n0 + 1);
        if (got_q.size() == n0 + 1) chk("midrst_byte", 32'(got_q[n0]), 32'h5A);
        idle(1);

        // Random frames against a frame-level model: good stop -> byte, bad stop -> error pulse
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        n0  = got_q.size();
        efe = 0;
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            logic       stop;
            int         gap;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap  = stop ? int'($urandom_range(0, BIT)) : int'(BIT + $urandom_range(0, BIT));
            if (stop) exp_q.push_back(b);
            else efe++;
            send_frame(b, stop, gap);
        end
        idle(2 * BIT);
        rand_rdy = 1'b0;
        idle(1);
        data_out_ready = 1'b1;
        idle(5);
        data_out_ready = 1'b0;
        @(negedge clk);
        chk("rand_cnt", got_q.size() - n0, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (n0 + k < got_q.size())
                chk($sformatf("rand_byte%0d", k), 32'(got_q[n0 + k]), 32'(exp_q[k]));
        end
        chk("rand_fe", fe_cnt - fe0, efe);
        chk("rand_ov", ov_cnt - ov0, 0);
        chk("hold_stability", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
